prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Receiving end of the program-load interface (prog_w / prog_addr / prog_data) that the processor bench drives.
- Owns the 256x32 instruction store and clears it after reset.
- Accepts program writes only inside an explicit load session, then releases the core (cpu_run) and serves registered instruction fetches.
- Sits between the external loader and the single-cycle core's fetch stage.

Parameters:
ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W (localparam)
DATA_W, 32, instruction width
NOP_WORD, 32'h0000_0000, value returned on fetch when not in RUN
CLEAR_ON_RELOAD, 1, 1 = a reload from RUN re-clears the store before LOAD

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, synchronous, active-low
prog_start  in  1  one-cycle pulse: open load session
prog_done  in  1  one-cycle pulse: close session, start core
prog_w  in  1  write enable for program word
prog_addr  in  ADDR_W  word address of program line
prog_data  in  DATA_W  program word
fetch_addr  in  ADDR_W  word address from PC (pc[9:2] upstream)
instr  out  DATA_W  fetched instruction, registered
cpu_run  out  1  high only in RUN; core holds PC at 0 while low
busy  out  1  high in CLEAR
load_count  out  ADDR_W+1  writes accepted this session, saturating at DEPTH
wr_err  out  1  sticky: write attempted outside LOAD

Behaviour:
- Reset (clr=0 at a clk edge):
  - state<=CLEAR, clr_ptr<=0, instr<=NOP_WORD, cpu_run<=0, load_count<=0, wr_err<=0, reload_pend<=0.
  - Memory contents are not reset directly; the CLEAR sweep zeroes them.
- Reset mid-LOAD or mid-RUN aborts the session; partial program contents are discarded by the sweep.
- FSM states: CLEAR, IDLE, LOAD, RUN.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle, clr_ptr++; busy=1.
  - After the write at DEPTH-1 (exactly DEPTH cycles), go to LOAD if reload_pend, else IDLE; clear reload_pend.
  - prog_start/prog_done are ignored in CLEAR; prog_w sets wr_err.
- IDLE:
  - prog_start -> LOAD, load_count<=0.
  - prog_done is ignored; prog_w sets wr_err, no write.
- LOAD:
  - prog_w=1 writes mem[prog_addr]<=prog_data at that edge.
  - load_count increments on each accepted write, overwrites included, saturating at DEPTH.
  - prog_done -> RUN next cycle.
  - prog_done and prog_w in the same cycle: the write is accepted, then go to RUN.
  - prog_start in LOAD: restart counting (load_count<=0); memory untouched.
- RUN:
  - cpu_run=1.
  - instr<=mem[fetch_addr] each edge, one-cycle latency; a new fetch_addr is reflected on instr after the next edge.
  - prog_w sets wr_err and does not write.
  - prog_start drops cpu_run in that same edge.
    - CLEAR_ON_RELOAD=1: go to CLEAR with reload_pend<=1.
    - CLEAR_ON_RELOAD=0: go to LOAD with load_count<=0.
- Outside RUN, instr<=NOP_WORD every edge.
- No read-during-write hazard: reads and writes never share a state.
- prog_start and prog_done asserted together:
  - In IDLE, prog_start wins.
  - In LOAD, prog_done wins.
- wr_err is cleared only by reset.
- Write in the last CLEAR cycle: rejected, wr_err set.
- Address wrap: clr_ptr is ADDR_W+1 bits, so the sweep terminates without aliasing. prog_addr is full-range, so no out-of-range case exists.

Decomposition:
- Package prog_mem_pkg:
  - state enum typedef (CLEAR, IDLE, LOAD, RUN)
  - ADDR_W/DATA_W defaults
  - NOP_WORD constant
- One sub-module, imem_1r1w: DEPTH x DATA_W array with one synchronous write port and one registered read port, inferable as block RAM.
- The loader FSM, counters and muxing stay in prog_mem_loader.

Test Plan:
- Reset:
  - Stimulus: assert clr=0 for 2 cycles, release.
  - Response: busy=1 for exactly 256 cycles, then IDLE; cpu_run=0, instr=0, load_count=0, wr_err=0.
- Load and run:
  - Stimulus: after CLEAR, prog_start; write addr0..7 with 32'h2008_0005+i; prog_done.
  - Response: load_count=8, cpu_run=1 next cycle; fetch_addr=3 gives instr=32'h2008_0008 one cycle later; fetch_addr=9 gives 0.
- Write outside LOAD:
  - Stimulus: in RUN, prog_w=1, prog_addr=2, data=32'hDEAD_BEEF.
  - Response: wr_err=1 (sticky); fetch 2 still returns 32'h2008_0007.
- Simultaneous write and done:
  - Stimulus: in LOAD, prog_w with addr 5, data 32'h1234_5678, together with prog_done.
  - Response: word stored, load_count increments, RUN entered; fetch 5 returns 32'h1234_5678.
- Reload with CLEAR_ON_RELOAD=1:
  - Stimulus: prog_start in RUN.
  - Response: cpu_run=0 at that edge, busy for 256 cycles, then LOAD with load_count=0; prog_done then fetch 3 returns 0.
- Reset mid-LOAD:
  - Stimulus: after 4 writes, clr=0.
  - Response: state CLEAR, load_count=0, all words read 0 after a later prog_start/prog_done.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory loader block.
// Contents:
//   state_t         loader FSM states (CLEAR, IDLE, LOAD, RUN)
//   ADDR_W_DEF      default word-address width
//   DATA_W_DEF      default instruction width
//   DEF_NOP_WORD    default word returned on fetch when the core is not running
package prog_mem_pkg;

   localparam int          ADDR_W_DEF   = 8;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_CLEAR,   // sweeping zeros through the store
      ST_IDLE,    // store clean, waiting for a load session
      ST_LOAD,    // accepting program writes
      ST_RUN      // core released, serving fetches
   } state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Bundle of the load and fetch signals between the external loader / core
// fetch stage (master) and the program memory loader (slave).
// Signals:
//   prog_start  open (or restart) a load session, one-cycle pulse
//   prog_done   close session and release the core, one-cycle pulse
//   prog_w      program word write enable
//   prog_addr   word address of the program line
//   prog_data   program word
//   fetch_addr  word address from the core PC
//   instr       fetched instruction, one cycle after fetch_addr
//   cpu_run     core may run
//   busy        store is being cleared
//   load_count  writes accepted this session, saturating at 2**ADDR_W
//   wr_err      sticky: a write was attempted outside a load session
interface prog_mem_loader_if
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              prog_start;
   logic              prog_done;
   logic              prog_w;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] instr;
   logic              cpu_run;
   logic              busy;
   logic [ADDR_W:0]   load_count;
   logic              wr_err;

   modport master (
      output prog_start, prog_done, prog_w, prog_addr, prog_data, fetch_addr,
      input  instr, cpu_run, busy, load_count, wr_err
   );

   modport slave (
      input  prog_start, prog_done, prog_w, prog_addr, prog_data, fetch_addr,
      output instr, cpu_run, busy, load_count, wr_err
   );
endinterface

// File: rtl/imem_1r1w.sv
// Instruction store: 2**ADDR_W x DATA_W array with one synchronous write
// port and one registered read port, shaped for block-RAM inference.
// Ports:
//   clk    clock, rising edge
//   we     write enable
//   waddr  write word address
//   wdata  write data
//   raddr  read word address
//   rdata  registered read data (previous-cycle raddr)
module imem_1r1w
   import prog_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: neither the array nor the read register has a reset; a reset
   // would block RAM inference. The loader's clear sweep and its output
   // mux give the defined values instead.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory loader: owns the instruction store, clears it after reset
// (and optionally on reload), accepts program writes only inside a load
// session, then releases the core and serves registered fetches.
// Ports:
//   clk   clock, rising edge
//   clr   synchronous active-low reset
//   bus   load/fetch bundle (slave side), see prog_mem_loader_if
module prog_mem_loader
   import prog_mem_pkg::*;
#(
   parameter int                ADDR_W          = ADDR_W_DEF,
   parameter int                DATA_W          = DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_WORD        = DATA_W'(DEF_NOP_WORD),
   parameter bit                CLEAR_ON_RELOAD = 1'b1
) (
   input logic               clk,
   input logic               clr,
   prog_mem_loader_if.slave  bus
);

   localparam int              DEPTH      = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_PTR   = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   clr_ptr;
   logic              reload_pend;
   logic [ADDR_W:0]   load_count;
   logic              wr_err;
   logic              run_q;
   logic              sweep_last;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign sweep_last = (clr_ptr == LAST_PTR);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path
   // leaves a variable unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_waddr = bus.prog_addr;
      mem_wdata = bus.prog_data;
      unique case (state)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr[ADDR_W-1:0];
            mem_wdata = '0;
            if (sweep_last) begin
               state_nxt = reload_pend ? ST_LOAD : ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.prog_start) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A write coinciding with prog_done is still stored.
            mem_we = bus.prog_w;
            if (bus.prog_done) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.prog_start) begin
               state_nxt = CLEAR_ON_RELOAD ? ST_CLEAR : ST_LOAD;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         clr_ptr     <= '0;
         reload_pend <= 1'b0;
         load_count  <= '0;
         wr_err      <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         // The read register only holds meaningful data for fetches issued
         // while running; run_q selects it on the following cycle.
         run_q <= (state == ST_RUN);

         if (bus.prog_w && (state != ST_LOAD)) begin
            wr_err <= 1'b1;
         end

         unique case (state)
            ST_CLEAR: begin
               clr_ptr <= sweep_last ? '0 : clr_ptr + 1'b1;
               if (sweep_last) begin
                  reload_pend <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (bus.prog_start) begin
                  load_count <= '0;
               end
            end
            ST_LOAD: begin
               // prog_done outranks prog_start; a restart still counts a
               // write accepted on the same edge.
               if (bus.prog_start && !bus.prog_done) begin
                  load_count <= {{ADDR_W{1'b0}}, bus.prog_w};
               end else if (bus.prog_w && (load_count != FULL_COUNT)) begin
                  load_count <= load_count + 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.prog_start) begin
                  load_count  <= '0;
                  reload_pend <= CLEAR_ON_RELOAD;
               end
            end
            default: ;
         endcase
      end
   end

   imem_1r1w #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_imem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (bus.fetch_addr),
      .rdata (mem_rdata)
   );

   assign bus.instr      = run_q ? mem_rdata : NOP_WORD;
   assign bus.cpu_run    = (state == ST_RUN);
   assign bus.busy       = (state == ST_CLEAR);
   assign bus.load_count = load_count;
   assign bus.wr_err     = wr_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the loader.
module tb_prog_mem_loader;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   prog_mem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   prog_mem_loader #(
      .ADDR_W          (8),
      .DATA_W          (32),
      .NOP_WORD        (32'h0000_0000),
      .CLEAR_ON_RELOAD (1'b1)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model: mode plus remaining sweep cycles; the store is
   // treated as zeroed in one go when the sweep finishes.
   localparam int M_SWEEP = 0, M_IDLE = 1, M_LOAD = 2, M_RUN = 3;
   int          m_mode;
   int          m_left;
   bit          m_reload;
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_instr;
   int          m_count;
   bit          m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict the effect of the coming rising edge from the current inputs.
   task automatic model_step();
      if (!clr) begin
         m_mode = M_SWEEP; m_left = DEPTH; m_reload = 0;
         m_instr = 32'h0; m_count = 0; m_err = 0;
      end else begin
         m_instr = (m_mode == M_RUN) ? m_mem[bus.fetch_addr] : 32'h0;
         if (bus.prog_w && m_mode != M_LOAD) m_err = 1;
         case (m_mode)
            M_SWEEP: begin
               m_left--;
               if (m_left == 0) begin
                  foreach (m_mem[i]) m_mem[i] = 32'h0;
                  m_mode   = m_reload ? M_LOAD : M_IDLE;
                  m_reload = 0;
               end
            end
            M_IDLE: if (bus.prog_start) begin m_mode = M_LOAD; m_count = 0; end
            M_LOAD: begin
               if (bus.prog_w) begin
                  m_mem[bus.prog_addr] = bus.prog_data;
                  m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
               end
               if (bus.prog_done) m_mode = M_RUN;
               else if (bus.prog_start) m_count = bus.prog_w ? 1 : 0;
            end
            default: if (bus.prog_start) begin
               m_count = 0; m_mode = M_SWEEP; m_left = DEPTH; m_reload = 1;
            end
         endcase
      end
   endtask

   task automatic compare_all();
      check("busy",       64'(bus.busy),       64'(m_mode == M_SWEEP));
      check("cpu_run",    64'(bus.cpu_run),    64'(m_mode == M_RUN));
      check("instr",      64'(bus.instr),      64'(m_instr));
      check("load_count", 64'(bus.load_count), 64'(m_count));
      check("wr_err",     64'(bus.wr_err),     64'(m_err));
   endtask

   // One clock: model predicts the edge, DUT takes it, outputs compared
   // at the falling edge.
   task automatic tick();
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      bus.prog_start = 0; bus.prog_done = 0; bus.prog_w = 0;
      bus.prog_addr = '0; bus.prog_data = '0;
   endtask

   task automatic pulse_start();
      bus.prog_start = 1; tick(); bus.prog_start = 0;
   endtask

   task automatic pulse_done();
      bus.prog_done = 1; tick(); bus.prog_done = 0;
   endtask

   task automatic write_word(input logic [7:0] a, input logic [31:0] d);
      bus.prog_w = 1; bus.prog_addr = a; bus.prog_data = d; tick(); bus.prog_w = 0;
   endtask

   task automatic fetch(input logic [7:0] a);
      bus.fetch_addr = a; tick();
   endtask

   // Counts cycles until busy drops, bounded so a stuck sweep still ends.
   task automatic wait_sweep(input string name);
      int n = 0;
      while (bus.busy && n < 400) begin tick(); n++; end
      check(name, 64'(n), 64'd256);
   endtask

   initial begin
      clr = 0;
      idle_inputs();
      bus.fetch_addr = '0;

      // Reset held for two cycles.
      tick(); tick();
      check("rst_busy",    64'(bus.busy),       64'd1);
      check("rst_cpu_run", 64'(bus.cpu_run),    64'd0);
      check("rst_instr",   64'(bus.instr),      64'd0);
      check("rst_count",   64'(bus.load_count), 64'd0);
      check("rst_wr_err",  64'(bus.wr_err),     64'd0);
      clr = 1;
      wait_sweep("clear_len_reset");

      // Load 8 words and run.
      pulse_start();
      for (int i = 0; i < 8; i++) write_word(8'(i), 32'h2008_0005 + 32'(i));
      check("count_8", 64'(bus.load_count), 64'd8);
      pulse_done();
      check("run_after_done", 64'(bus.cpu_run), 64'd1);
      fetch(8'd3);
      check("fetch_3", 64'(bus.instr), 64'h2008_0008);
      fetch(8'd9);
      check("fetch_9", 64'(bus.instr), 64'h0);

      // Write attempted while running.
      write_word(8'd2, 32'hDEAD_BEEF);
      check("wr_err_run", 64'(bus.wr_err), 64'd1);
      fetch(8'd2);
      check("fetch_2_kept", 64'(bus.instr), 64'h2008_0007);

      // Reload: clears store, returns to LOAD.
      pulse_start();
      check("reload_cpu_run", 64'(bus.cpu_run), 64'd0);
      wait_sweep("clear_len_reload");
      check("reload_count", 64'(bus.load_count), 64'd0);

      // Write together with prog_done.
      bus.prog_done = 1;
      write_word(8'd5, 32'h1234_5678);
      bus.prog_done = 0;
      check("count_wr_done", 64'(bus.load_count), 64'd1);
      check("run_wr_done",   64'(bus.cpu_run),    64'd1);
      fetch(8'd5);
      check("fetch_5", 64'(bus.instr), 64'h1234_5678);
      fetch(8'd3);
      check("fetch_3_cleared", 64'(bus.instr), 64'h0);

      // Saturation of load_count.
      pulse_start();
      wait_sweep("clear_len_sat");
      for (int i = 0; i < 260; i++) write_word(8'($urandom), $urandom);
      check("count_sat", 64'(bus.load_count), 64'd256);
      pulse_done();

      // Reset in the middle of a load session.
      pulse_start();
      wait_sweep("clear_len_reload2");
      for (int i = 0; i < 4; i++) write_word(8'(i), 32'hA5A5_0000 + 32'(i));
      clr = 0; tick();
      check("midload_count", 64'(bus.load_count), 64'd0);
      check("midload_busy",  64'(bus.busy),       64'd1);
      check("midload_err",   64'(bus.wr_err),     64'd0);
      clr = 1;
      wait_sweep("clear_len_midload");
      pulse_start();
      pulse_done();
      for (int a = 0; a < DEPTH; a++) begin
         fetch(8'(a));
         check("all_zero", 64'(bus.instr), 64'h0);
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 8000; c++) begin
         clr            = ($urandom_range(0, 999) != 0);
         bus.prog_start = ($urandom_range(0, 59) == 0);
         bus.prog_done  = ($urandom_range(0, 24) == 0);
         bus.prog_w     = ($urandom_range(0, 2) == 0);
         bus.prog_addr  = 8'($urandom_range(0, 15));
         bus.prog_data  = $urandom;
         bus.fetch_addr = 8'($urandom_range(0, 15));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
